// File: rtl/traffic_pkg.sv
// Shared traffic-light definitions: phase encoding used by the timer and the sequencer,
// default phase durations, and a helper to size tick counters.
package traffic_pkg;

  localparam logic [1:0] RED       = 2'd0;
  localparam logic [1:0] RED_AMBER = 2'd1;
  localparam logic [1:0] GREEN     = 2'd2;
  localparam logic [1:0] AMBER     = 2'd3;

  localparam int unsigned DEF_T_RED       = 8;
  localparam int unsigned DEF_T_RED_AMBER = 2;
  localparam int unsigned DEF_T_GREEN_MIN = 4;
  localparam int unsigned DEF_T_GREEN_MAX = 16;
  localparam int unsigned DEF_T_AMBER     = 3;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level input, followed by a rising-edge detector.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      prev_q <= sync_q[1];
    end
  end

  assign rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase timer for the traffic light sequencer: holds each lamp phase for a programmed number
// of prescaler ticks, pulses step on every phase change and serves pedestrian requests.
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned T_RED       = DEF_T_RED,
  parameter int unsigned T_RED_AMBER = DEF_T_RED_AMBER,
  parameter int unsigned T_GREEN_MIN = DEF_T_GREEN_MIN,
  parameter int unsigned T_GREEN_MAX = DEF_T_GREEN_MAX,
  parameter int unsigned T_AMBER     = DEF_T_AMBER,
  parameter int unsigned CNT_W       = $clog2(max4(T_RED, T_RED_AMBER, T_GREEN_MAX, T_AMBER) + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             ped_req,
  output logic             step,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] remaining,
  output logic             ped_wait,
  output logic             ped_walk
);

  if (T_RED < 1 || T_RED_AMBER < 1 || T_GREEN_MIN < 1 || T_GREEN_MAX < 1 || T_AMBER < 1 ||
      T_GREEN_MIN > T_GREEN_MAX) begin : g_bad_params
    $error("traffic_phase_timer: illegal phase durations");
  end

  localparam logic [CNT_W-1:0] DUR_RED       = CNT_W'(T_RED);
  localparam logic [CNT_W-1:0] DUR_RED_AMBER = CNT_W'(T_RED_AMBER);
  localparam logic [CNT_W-1:0] DUR_GREEN_MIN = CNT_W'(T_GREEN_MIN);
  localparam logic [CNT_W-1:0] DUR_GREEN_MAX = CNT_W'(T_GREEN_MAX);
  localparam logic [CNT_W-1:0] DUR_AMBER     = CNT_W'(T_AMBER);

  // Reset release is synchronized; counting starts once run goes high.
  logic [1:0] rst_sync_q;
  logic       run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign run = rst_sync_q[1];

  logic ped_rise;

  sync_edge u_ped_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ped_req),
    .rise  (ped_rise)
  );

  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d, elapsed_inc, dur;
  logic             expire, step_q;
  logic             wait_q, wait_d, walk_q, walk_d;

  always_comb begin
    dur = DUR_RED;
    unique case (phase_q)
      RED:       dur = DUR_RED;
      RED_AMBER: dur = DUR_RED_AMBER;
      GREEN:     dur = DUR_GREEN_MAX;
      AMBER:     dur = DUR_AMBER;
      default:   dur = DUR_RED;
    endcase
  end

  assign elapsed_inc = elapsed_q + CNT_W'(1);

  always_comb begin
    expire    = 1'b0;
    phase_d   = phase_q;
    elapsed_d = elapsed_q;
    if (run && tick) begin
      elapsed_d = elapsed_inc;
      if (elapsed_inc == dur) begin
        expire = 1'b1;
      end else if (phase_q == GREEN && wait_q && elapsed_inc >= DUR_GREEN_MIN) begin
        expire = 1'b1;
      end
    end
    if (expire) begin
      phase_d   = phase_q + 2'd1;  // encoding order is the cyclic phase order
      elapsed_d = '0;
    end
  end

  // A request edge on the RED-entry cycle is folded straight into the walk grant.
  always_comb begin
    wait_d = wait_q;
    walk_d = walk_q;
    if (ped_rise && !walk_q) wait_d = 1'b1;
    if (expire && phase_q == RED) walk_d = 1'b0;
    if (expire && phase_q == AMBER && wait_d) begin
      walk_d = 1'b1;
      wait_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= RED;
      elapsed_q <= '0;
      step_q    <= 1'b0;
      wait_q    <= 1'b0;
      walk_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      elapsed_q <= elapsed_d;
      step_q    <= expire;
      wait_q    <= wait_d;
      walk_q    <= walk_d;
    end
  end

  assign step      = step_q;
  assign phase     = phase_q;
  assign remaining = dur - elapsed_q;
  assign ped_wait  = wait_q;
  assign ped_walk  = walk_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Scoreboard bench for traffic_phase_timer: each expected phase change is queued when the
// stimulus is planned and checked against the DUT when step fires.
module tb_traffic_phase_timer;

  localparam int unsigned T_RED = 8;
  localparam int unsigned CW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          ped_req = 1'b0;
  logic          step;
  logic [1:0]    phase;
  logic [CW-1:0] remaining;
  logic          ped_wait;
  logic          ped_walk;

  traffic_phase_timer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .ped_req   (ped_req),
    .step      (step),
    .phase     (phase),
    .remaining (remaining),
    .ped_wait  (ped_wait),
    .ped_walk  (ped_walk)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ph;
    int         tk;
    logic       walk;
    logic       wt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   ticks_sampled = 0;
  int   n_steps = 0;
  logic prev_step = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_step(input logic [1:0] ph, input int tk, input logic walk,
                             input logic wt);
    exp_t e;
    e.ph = ph; e.tk = tk; e.walk = walk; e.wt = wt;
    sb.push_back(e);
  endtask

  task automatic clk_step();
    exp_t e;
    @(posedge clk);
    if (tick) ticks_sampled++;
    #1;
    check_eq("remaining_nonzero", remaining != 0, 1);
    if (step) begin
      n_steps++;
      check_eq("step_width", prev_step, 0);
      if (sb.size() == 0) begin
        check_eq("step_expected", step, 0);
      end else begin
        e = sb.pop_front();
        check_eq("step_phase", phase, e.ph);
        check_eq("step_walk", ped_walk, e.walk);
        check_eq("step_wait", ped_wait, e.wt);
        if (e.tk >= 0) check_eq("step_tick", ticks_sampled, e.tk);
      end
    end
    prev_step = step;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    repeat (3) clk_step();
  endtask

  task automatic run_ticks(input int n);
    repeat (n) tick_pulse();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_phase"}, phase, 0);
    check_eq({tag, "_remaining"}, remaining, T_RED);
    check_eq({tag, "_step"}, step, 0);
    check_eq({tag, "_wait"}, ped_wait, 0);
    check_eq({tag, "_walk"}, ped_walk, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    int steps0;
    int first;
    int stepat;

    // Reset and idle
    #2;
    check_reset_outputs("in_reset");
    repeat (2) clk_step();
    rst_n = 1'b1;
    repeat (20) begin
      clk_step();
      check_reset_outputs("idle");
    end

    // Free-running cycle, no requests
    b = ticks_sampled;
    steps0 = n_steps;
    expect_step(2'd1, b + 8, 1'b0, 1'b0);
    expect_step(2'd2, b + 10, 1'b0, 1'b0);
    expect_step(2'd3, b + 26, 1'b0, 1'b0);
    expect_step(2'd0, b + 29, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      tick_pulse();
      check_eq("red_countdown", remaining, T_RED - k);
    end
    run_ticks(22);
    check_eq("cycle_steps", n_steps - steps0, 4);

    // Request early in GREEN
    b = ticks_sampled;
    expect_step(2'd1, b + 8, 1'b0, 1'b0);
    expect_step(2'd2, b + 10, 1'b0, 1'b0);
    run_ticks(11);
    ped_req = 1'b1;
    clk_step();
    ped_req = 1'b0;
    clk_step();
    check_eq("wait_latency_early", ped_wait, 0);
    clk_step();
    check_eq("wait_latency_3clk", ped_wait, 1);
    expect_step(2'd3, b + 14, 1'b0, 1'b1);
    expect_step(2'd0, b + 17, 1'b1, 1'b0);
    run_ticks(6);
    check_eq("walk_in_red", ped_walk, 1);
    expect_step(2'd1, b + 25, 1'b0, 1'b0);
    run_ticks(8);
    check_eq("walk_after_red", ped_walk, 0);

    // Request late in GREEN
    b = ticks_sampled;
    expect_step(2'd2, b + 2, 1'b0, 1'b0);
    run_ticks(12);
    ped_req = 1'b1;
    clk_step();
    ped_req = 1'b0;
    repeat (3) clk_step();
    check_eq("late_wait", ped_wait, 1);
    expect_step(2'd3, b + 13, 1'b0, 1'b1);
    expect_step(2'd0, b + 16, 1'b1, 1'b0);
    expect_step(2'd1, b + 24, 1'b0, 1'b0);
    run_ticks(12);

    // Held button plus presses during walk
    b = ticks_sampled;
    ped_req = 1'b1;
    repeat (4) clk_step();
    check_eq("held_wait", ped_wait, 1);
    expect_step(2'd2, b + 2, 1'b0, 1'b1);
    expect_step(2'd3, b + 6, 1'b0, 1'b1);
    expect_step(2'd0, b + 9, 1'b1, 1'b0);
    run_ticks(11);
    repeat (2) begin
      ped_req = 1'b0;
      repeat (4) clk_step();
      ped_req = 1'b1;
      repeat (4) clk_step();
    end
    ped_req = 1'b0;
    check_eq("walk_presses_ignored", ped_wait, 0);
    expect_step(2'd1, b + 17, 1'b0, 1'b0);
    expect_step(2'd2, b + 19, 1'b0, 1'b0);
    expect_step(2'd3, b + 35, 1'b0, 1'b0);
    expect_step(2'd0, b + 38, 1'b0, 1'b0);
    run_ticks(27);
    check_eq("served_once_wait", ped_wait, 0);
    check_eq("served_once_walk", ped_walk, 0);

    // Continuous tick, reset mid-GREEN, restart
    b = ticks_sampled;
    expect_step(2'd1, b + 8, 1'b0, 1'b0);
    expect_step(2'd2, b + 10, 1'b0, 1'b0);
    tick = 1'b1;
    repeat (15) clk_step();
    check_eq("pre_reset_phase", phase, 2);
    check_eq("pre_reset_sb", sb.size(), 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (3) begin
      clk_step();
      check_reset_outputs("held_reset");
    end
    expect_step(2'd1, -1, 1'b0, 1'b0);
    rst_n = 1'b1;
    first = -1;
    stepat = -1;
    for (int i = 1; i <= 40 && stepat < 0; i++) begin
      clk_step();
      if (first < 0 && remaining != T_RED) first = i;
      if (step) stepat = i;
    end
    tick = 1'b0;
    check_eq("restart_step_seen", stepat > 0, 1);
    check_eq("restart_first_count_edge", first >= 2, 1);
    check_eq("restart_red_cycles", stepat - first + 1, T_RED);
    clk_step();
    check_eq("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
